// File: rtl/aad_mean_divider_if.sv
// aad_mean_divider_if
//   Handshake bundle for the mean-absolute-difference divider.
//   Operand side : in_valid/in_ready with sum_in (dividend) and count_in (divisor).
//   Result side  : out_valid/out_ready with mean_q, mean_r and div_zero.
//   acc_clr      : one-cycle pulse from the divider to the accumulator.
//   Modports:
//     master - producer/consumer surrounding the divider (drives operands, out_ready)
//     slave  - the divider itself
interface aad_mean_divider_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum_in;
  logic [W-1:0] count_in;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] mean_q;
  logic [W-1:0] mean_r;
  logic         div_zero;

  modport master (
    output in_valid, sum_in, count_in, out_ready,
    input  in_ready, acc_clr, out_valid, mean_q, mean_r, div_zero
  );

  modport slave (
    input  in_valid, sum_in, count_in, out_ready,
    output in_ready, acc_clr, out_valid, mean_q, mean_r, div_zero
  );
endinterface

// File: rtl/aad_mean_divider.sv
// aad_mean_divider
//   Sequential restoring divider at the read end of the absolute-difference
//   accumulator. Takes the accumulated |a-b| sum and the sample count, returns
//   quotient (mean) and remainder, one quotient bit per cycle, and pulses
//   acc_clr the cycle after accepting so the accumulator starts a new window.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - aad_mean_divider_if.slave: in_valid/in_ready/sum_in/count_in,
//              out_valid/out_ready/mean_q/mean_r/div_zero, acc_clr
//   Optional feature:
//     AAD_DIV_ROUND_EN - adds a one-cycle ROUND state that rounds the quotient
//                        to nearest (2*r >= count bumps q, r becomes r-count mod 2^W).
//   Latency: W+1 cycles from accept to out_valid (W+2 with rounding), 1 for count==0.
module aad_mean_divider #(
  parameter int unsigned W = 8
) (
  input logic             clk,
  input logic             rst_n,
  aad_mean_divider_if.slave bus
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [W-1:0]  dividend;   // shifts out dividend bits, shifts in quotient bits
  logic [W-1:0]  divisor;
  logic [W-1:0]  rem;        // partial remainder; always < divisor so W bits suffice
  logic [CW-1:0] cnt;
  logic          acc_clr;
  logic [W-1:0]  mean_q;
  logic [W-1:0]  mean_r;
  logic          div_zero;

  // One restoring step: the W+1 bit shifted remainder is compared against the divisor.
  logic [W:0]    r_shift;
  logic          q_bit;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  q_next;

  always_comb begin
    r_shift  = {rem, dividend[W-1]};
    q_bit    = (r_shift >= {1'b0, divisor});
    rem_next = q_bit ? W'(r_shift - {1'b0, divisor}) : r_shift[W-1:0];
    q_next   = W'({dividend, q_bit});
  end

`ifdef AAD_DIV_ROUND_EN
  logic round_up;

  always_comb begin
    round_up = ({mean_r, 1'b0} >= {1'b0, divisor});
  end
`endif

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.acc_clr   = acc_clr;
  assign bus.mean_q    = mean_q;
  assign bus.mean_r    = mean_r;
  assign bus.div_zero  = div_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      cnt      <= '0;
      acc_clr  <= 1'b0;
      mean_q   <= '0;
      mean_r   <= '0;
      div_zero <= 1'b0;
    end else begin
      acc_clr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            dividend <= bus.sum_in;
            divisor  <= bus.count_in;
            rem      <= '0;
            cnt      <= CW'(W - 1);
            acc_clr  <= 1'b1;
            if (bus.count_in == '0) begin
              mean_q   <= '1;
              mean_r   <= bus.sum_in;
              div_zero <= 1'b1;
              state    <= S_DONE;
            end else begin
              div_zero <= 1'b0;
              state    <= S_DIV;
            end
          end
        end

        S_DIV: begin
          dividend <= q_next;
          rem      <= rem_next;
          if (cnt == '0) begin
            // Final step: publish straight from the step logic so DONE follows immediately.
            mean_q <= q_next;
            mean_r <= rem_next;
`ifdef AAD_DIV_ROUND_EN
            state  <= S_ROUND;
`else
            state  <= S_DONE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

`ifdef AAD_DIV_ROUND_EN
        S_ROUND: begin
          if (round_up) begin
            mean_q <= mean_q + 1'b1;
            mean_r <= mean_r - divisor;
          end
          state <= S_DONE;
        end
`endif

        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aad_mean_divider.sv
`timescale 1ns/1ps
module tb_aad_mean_divider;
  localparam int unsigned W = 8;
`ifdef AAD_DIV_ROUND_EN
  localparam int LAT = W + 2;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = W + 1;
  localparam bit RND = 1'b0;
`endif
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aad_mean_divider_if #(.W(W)) bus();

  aad_mean_divider #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: truncating divide, optionally rounded to nearest.
  function automatic void ref_div(input int s, input int c, output int q, output int r, output int dz);
    if (c == 0) begin
      q = MASK; r = s; dz = 1;
    end else begin
      q = s / c; r = s % c; dz = 0;
      if (RND && (2 * r >= c)) begin
        q = q + 1;
        r = (r - c) & MASK;
      end
    end
  endfunction

  // Transaction-level model: a result appears a fixed number of cycles after
  // acceptance and is held until the consumer takes it.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t m_ph = M_IDLE;
  int  m_cnt = 0;
  bit  m_acc = 1'b0;
  bit  e_rdy = 1'b1, e_ov = 1'b0, e_clr = 1'b0;
  int  e_q = 0, e_r = 0, e_dz = 0;
  int  p_q, p_r, p_dz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = M_IDLE; m_cnt = 0; m_acc = 1'b0;
      e_clr = 1'b0; e_q = 0; e_r = 0; e_dz = 0;
    end else begin
      m_acc = 1'b0;
      e_clr = 1'b0;
      case (m_ph)
        M_IDLE: if (bus.in_valid) begin
          m_acc = 1'b1;
          e_clr = 1'b1;
          ref_div(int'(bus.sum_in), int'(bus.count_in), p_q, p_r, p_dz);
          if (bus.count_in == 0) begin
            e_q = p_q; e_r = p_r; e_dz = p_dz; m_ph = M_DONE;
          end else begin
            m_cnt = LAT - 1; m_ph = M_BUSY;
          end
        end
        M_BUSY: begin
          m_cnt--;
          if (m_cnt == 0) begin
            e_q = p_q; e_r = p_r; e_dz = p_dz; m_ph = M_DONE;
          end
        end
        M_DONE: if (bus.out_ready) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
    e_rdy = (m_ph == M_IDLE);
    e_ov  = (m_ph == M_DONE);
  end

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    chk("in_ready", bus.in_ready, e_rdy);
    chk("out_valid", bus.out_valid, e_ov);
    chk("acc_clr", bus.acc_clr, e_clr);
    if (e_ov || !rst_n) begin
      chk("mean_q", bus.mean_q, e_q);
      chk("mean_r", bus.mean_r, e_r);
      chk("div_zero", bus.div_zero, e_dz);
    end
  end

  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.out_valid && n < 4 * LAT) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Directed operation with literal expectations; assumes DUT idle and out_ready=1.
  task automatic op(input int s, input int c, input int eq, input int er);
    int n;
    bus.sum_in = W'(s); bus.count_in = W'(c); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("acc_clr_pulse", bus.acc_clr, 1);
    wait_valid(n);
    chk("latency", n, (c == 0) ? 1 : LAT);
    chk("q_lit", bus.mean_q, eq);
    chk("r_lit", bus.mean_r, er);
    chk("dz_lit", bus.div_zero, (c == 0) ? 1 : 0);
    @(posedge clk); #1;
  endtask

  int n;

  initial begin
    bus.in_valid = 1'b0; bus.sum_in = '0; bus.count_in = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    op(100, 7, 14, 2);
    op(255, 1, 255, 0);
    op(0, 9, 0, 0);
`ifdef AAD_DIV_ROUND_EN
    op(104, 7, 15, 255);
    op(255, 2, 128, 255);
`else
    op(104, 7, 14, 6);
    op(255, 2, 127, 1);
`endif
    op(37, 0, 255, 37);

    // Back-pressure: result held, second operand waits.
    bus.out_ready = 1'b0;
    bus.sum_in = 8'd200; bus.count_in = 8'd9; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.sum_in = 8'd50; bus.count_in = 8'd5;
    wait_valid(n);
    chk("bp_latency", n, LAT);
    repeat (20) begin
      @(posedge clk); #1;
      chk("bp_hold_q", bus.mean_q, 22);
      chk("bp_hold_r", bus.mean_r, 2);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", bus.in_ready, 1);
    chk("bp_idle_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("bp_second_clr", bus.acc_clr, 1);
    bus.in_valid = 1'b0;
    wait_valid(n);
    chk("bp_second_q", bus.mean_q, 10);
    chk("bp_second_r", bus.mean_r, 0);
    @(posedge clk); #1;

    // Reset in the middle of a division.
    bus.sum_in = 8'd77; bus.count_in = 8'd6; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_q", bus.mean_q, 0);
    chk("rst_r", bus.mean_r, 0);
    chk("rst_dz", bus.div_zero, 0);
    chk("rst_clr", bus.acc_clr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef AAD_DIV_ROUND_EN
    op(77, 6, 13, 255);
`else
    op(77, 6, 12, 5);
`endif

    // Randomized traffic with random back-pressure; producer holds data until accepted.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (!bus.in_valid || m_acc) begin
        if ($urandom_range(0, 3) != 0) begin
          bus.in_valid = 1'b1;
          bus.sum_in   = W'($urandom_range(0, MASK));
          if ($urandom_range(0, 7) == 0)
            bus.count_in = '0;
          else
            bus.count_in = W'($urandom_range(1, ($urandom_range(0, 1) != 0) ? 15 : MASK));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    if (!m_acc) bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3 * LAT) @(posedge clk);
    #1;
    chk("drain_idle", bus.in_ready, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
